pong_match_controller: RTL and testbench

- Match-level sequencer for the VGA pong datapath.
- Decides when the ball is held at centre and when it runs, which way it serves and at what speed.
- Keeps both players' scores and declares the winner.
- Sits between the board keys and the ball/paddle update logic. It is advanced by a once-per-frame tick taken from the VGA vertical counter wrap.

---
 rtl/pong_match_controller.sv | 217 +++++++++++++++++++++
 tb/tb_pong_match_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_controller.sv
`timescale 1ns/1ps
// Match sequencer for the VGA pong datapath: serve/play/point/game-over flow, scores, winner, ball speed.
// Optional speed ramp on paddle hits is built when PONG_SPEED_RAMP_EN is defined.
module pong_match_controller #(
  parameter int WIN_SCORE     = 5,
  parameter int SERVE_FRAMES  = 60,
  parameter int POINT_FRAMES  = 90,
  parameter int BASE_SPEED    = 3,
  parameter int MAX_SPEED     = 7,
  parameter int HITS_PER_STEP = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       frame_tick,
  input  logic       start_n,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       paddle_hit,
  output logic       ball_reset,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] speed,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SERVE = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_POINT = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       WIN_4     = 4'(WIN_SCORE);
  localparam logic [3:0]       BASE_4    = 4'(BASE_SPEED);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_p1;
  logic [3:0]       r_p2;
  logic [1:0]       r_winner;
  logic             r_dir;
  logic [3:0]       r_speed;
  logic             r_run;
  logic             r_reset_out;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_prev;

  logic             w_start_press;
  logic [2:0]       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [3:0]       w_nxt_p1;
  logic [3:0]       w_nxt_p2;
  logic [1:0]       w_nxt_winner;
  logic             w_nxt_dir;
  logic             w_serve_entry;
  logic [3:0]       w_p1_inc;
  logic [3:0]       w_p2_inc;

  // Key is a raw asynchronous level; pulse on the synchronised high-to-low transition.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= start_n;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_start_press = r_sync_prev & ~r_sync2;
  assign w_p1_inc      = r_p1 + 4'd1;
  assign w_p2_inc      = r_p2 + 4'd1;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_p1     = r_p1;
    w_nxt_p2     = r_p2;
    w_nxt_winner = r_winner;
    w_nxt_dir    = r_dir;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_start_press) begin
          w_nxt_state  = ST_SERVE;
          w_nxt_cnt    = CNT_SERVE;
          w_nxt_p1     = 4'd0;
          w_nxt_p2     = 4'd0;
          w_nxt_winner = 2'b00;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (r_cnt == CNT_ONE) w_nxt_state = ST_PLAY;
          else                  w_nxt_cnt   = r_cnt - CNT_ONE;
        end
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          w_nxt_state = ST_POINT;
          w_nxt_cnt   = CNT_POINT;
        end else if (miss_left) begin
          w_nxt_p2  = w_p2_inc;
          w_nxt_dir = 1'b0;
          if (w_p2_inc == WIN_4) begin
            w_nxt_state  = ST_OVER;
            w_nxt_winner = 2'b10;
          end else begin
            w_nxt_state = ST_POINT;
            w_nxt_cnt   = CNT_POINT;
          end
        end else if (miss_right) begin
          w_nxt_p1  = w_p1_inc;
          w_nxt_dir = 1'b1;
          if (w_p1_inc == WIN_4) begin
            w_nxt_state  = ST_OVER;
            w_nxt_winner = 2'b01;
          end else begin
            w_nxt_state = ST_POINT;
            w_nxt_cnt   = CNT_POINT;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (r_cnt == CNT_ONE) begin
            w_nxt_state = ST_SERVE;
            w_nxt_cnt   = CNT_SERVE;
          end else begin
            w_nxt_cnt = r_cnt - CNT_ONE;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  assign w_serve_entry = (w_nxt_state == ST_SERVE) && (r_state != ST_SERVE);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_p1        <= 4'd0;
      r_p2        <= 4'd0;
      r_winner    <= 2'b00;
      r_dir       <= 1'b1;
      r_run       <= 1'b0;
      r_reset_out <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_p1        <= w_nxt_p1;
      r_p2        <= w_nxt_p2;
      r_winner    <= w_nxt_winner;
      r_dir       <= w_nxt_dir;
      r_run       <= (w_nxt_state == ST_PLAY);
      r_reset_out <= (w_nxt_state != ST_PLAY);
    end
  end

`ifdef PONG_SPEED_RAMP_EN
  localparam int HIT_W = $clog2(HITS_PER_STEP + 1);
  localparam logic [HIT_W-1:0] HIT_STEP = HIT_W'(HITS_PER_STEP);
  localparam logic [3:0]       MAX_4    = 4'(MAX_SPEED);

  logic [HIT_W-1:0] r_hits;
  logic             w_lone_hit;

  assign w_lone_hit = (r_state == ST_PLAY) && paddle_hit && !miss_left && !miss_right;

  // Hit counter wraps at HITS_PER_STEP; each wrap bumps speed up to the ceiling.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hits  <= '0;
      r_speed <= BASE_4;
    end else if (w_serve_entry) begin
      r_hits  <= '0;
      r_speed <= BASE_4;
    end else if (w_lone_hit) begin
      if (r_hits + HIT_W'(1) == HIT_STEP) begin
        r_hits <= '0;
        if (r_speed < MAX_4) r_speed <= r_speed + 4'd1;
      end else begin
        r_hits <= r_hits + HIT_W'(1);
      end
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = paddle_hit ^ (HITS_PER_STEP == MAX_SPEED);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)           r_speed <= BASE_4;
    else if (w_serve_entry) r_speed <= BASE_4;
  end
`endif

  assign state      = r_state;
  assign ball_run   = r_run;
  assign ball_reset = r_reset_out;
  assign serve_dir  = r_dir;
  assign speed      = r_speed;
  assign score_p1   = r_p1;
  assign score_p2   = r_p2;
  assign winner     = r_winner;

endmodule

// File: tb/tb_pong_match_controller.sv
`timescale 1ns/1ps
// Directed bench for pong_match_controller with short frame counts and a two-point match.
module tb_pong_match_controller;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       frame_tick;
  logic       start_n;
  logic       miss_left;
  logic       miss_right;
  logic       paddle_hit;
  logic       ball_reset;
  logic       ball_run;
  logic       serve_dir;
  logic [3:0] speed;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] winner;
  logic [2:0] state;

  int checks;
  int failures;
  logic [19:0] exp_q[$];

`ifdef PONG_SPEED_RAMP_EN
  localparam logic [3:0] SPD_AFTER4  = 4'd4;
  localparam logic [3:0] SPD_AFTER20 = 4'd7;
`else
  localparam logic [3:0] SPD_AFTER4  = 4'd3;
  localparam logic [3:0] SPD_AFTER20 = 4'd3;
`endif

  pong_match_controller #(
    .WIN_SCORE(2), .SERVE_FRAMES(3), .POINT_FRAMES(2),
    .BASE_SPEED(3), .MAX_SPEED(7), .HITS_PER_STEP(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .frame_tick(frame_tick),
    .start_n(start_n), .miss_left(miss_left), .miss_right(miss_right),
    .paddle_hit(paddle_hit), .ball_reset(ball_reset), .ball_run(ball_run),
    .serve_dir(serve_dir), .speed(speed), .score_p1(score_p1),
    .score_p2(score_p2), .winner(winner), .state(state)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // driver tasks (inputs change on the falling edge)
  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_events(input logic l, input logic r, input logic h);
    miss_left  = l;
    miss_right = r;
    paddle_hit = h;
    step(1);
    miss_left  = 1'b0;
    miss_right = 1'b0;
    paddle_hit = 1'b0;
  endtask

  // scoreboard
  task automatic expect_out(input logic [2:0] st, input logic run, input logic dir,
                            input logic [3:0] spd, input logic [3:0] p1,
                            input logic [3:0] p2, input logic [1:0] win);
    exp_q.push_back({st, run, ~run, dir, spd, p1, p2, win});
  endtask

  task automatic check_out(input string tag);
    logic [19:0] e;
    logic [19:0] o;
    o = {state, ball_run, ball_reset, serve_dir, speed, score_p1, score_p2, winner};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed st=%0d run=%b rst=%b dir=%b spd=%0d p1=%0d p2=%0d win=%b expected st=%0d run=%b rst=%b dir=%b spd=%0d p1=%0d p2=%0d win=%b",
               tag, o[19:17], o[16], o[15], o[14], o[13:10], o[9:6], o[5:2], o[1:0],
               e[19:17], e[16], e[15], e[14], e[13:10], e[9:6], e[5:2], e[1:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RESET_N = 1'b0;
    frame_tick = 1'b0;
    start_n = 1'b1;
    miss_left = 1'b0;
    miss_right = 1'b0;
    paddle_hit = 1'b0;

    step(2);
    expect_out(3'd0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("reset_values");
    RESET_N = 1'b1;
    step(2);
    expect_out(3'd0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("idle_after_reset");

    // start key held for 10 cycles
    start_n = 1'b0;
    step(2);
    expect_out(3'd0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("press_not_yet");
    step(1);
    expect_out(3'd1, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("start_to_serve");
    step(7);
    expect_out(3'd1, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("held_key_no_effect");
    start_n = 1'b1;
    do_ticks(2);
    expect_out(3'd1, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("serve_two_ticks");
    do_tick();
    expect_out(3'd2, 1'b1, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("serve_to_play");

    // P1 scores
    do_events(1'b0, 1'b1, 1'b0);
    expect_out(3'd3, 1'b0, 1'b1, 4'd3, 4'd1, 4'd0, 2'b00);
    check_out("miss_right");
    do_tick();
    expect_out(3'd3, 1'b0, 1'b1, 4'd3, 4'd1, 4'd0, 2'b00);
    check_out("point_one_tick");
    do_tick();
    expect_out(3'd1, 1'b0, 1'b1, 4'd3, 4'd1, 4'd0, 2'b00);
    check_out("point_to_serve");
    do_ticks(2);
    expect_out(3'd1, 1'b0, 1'b1, 4'd3, 4'd1, 4'd0, 2'b00);
    check_out("reserve_hold");
    do_tick();
    expect_out(3'd2, 1'b1, 1'b1, 4'd3, 4'd1, 4'd0, 2'b00);
    check_out("reserve_to_play");

    // P2 scores, serve flips left
    do_events(1'b1, 1'b0, 1'b0);
    expect_out(3'd3, 1'b0, 1'b0, 4'd3, 4'd1, 4'd1, 2'b00);
    check_out("miss_left");
    do_ticks(5);
    expect_out(3'd2, 1'b1, 1'b0, 4'd3, 4'd1, 4'd1, 2'b00);
    check_out("back_to_play_a");

    // double miss with a coincident hit
    do_events(1'b1, 1'b1, 1'b1);
    expect_out(3'd3, 1'b0, 1'b0, 4'd3, 4'd1, 4'd1, 2'b00);
    check_out("double_miss");
    do_ticks(5);
    expect_out(3'd2, 1'b1, 1'b0, 4'd3, 4'd1, 4'd1, 2'b00);
    check_out("back_to_play_b");

    // paddle hits
    for (int i = 0; i < 4; i++) do_events(1'b0, 1'b0, 1'b1);
    expect_out(3'd2, 1'b1, 1'b0, SPD_AFTER4, 4'd1, 4'd1, 2'b00);
    check_out("hits_4");
    for (int i = 0; i < 16; i++) do_events(1'b0, 1'b0, 1'b1);
    expect_out(3'd2, 1'b1, 1'b0, SPD_AFTER20, 4'd1, 4'd1, 2'b00);
    check_out("hits_20");
    do_tick();
    expect_out(3'd2, 1'b1, 1'b0, SPD_AFTER20, 4'd1, 4'd1, 2'b00);
    check_out("tick_in_play");

    // P2 reaches the winning score
    do_events(1'b1, 1'b0, 1'b0);
    expect_out(3'd4, 1'b0, 1'b0, SPD_AFTER20, 4'd1, 4'd2, 2'b10);
    check_out("p2_wins");
    do_events(1'b0, 1'b1, 1'b0);
    do_events(1'b1, 1'b0, 1'b1);
    do_ticks(3);
    expect_out(3'd4, 1'b0, 1'b0, SPD_AFTER20, 4'd1, 4'd2, 2'b10);
    check_out("over_holds");

    start_n = 1'b0;
    step(3);
    expect_out(3'd1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("restart");
    start_n = 1'b1;
    step(3);
    do_ticks(3);
    expect_out(3'd2, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("restart_play");

    // reset while POINT counter sits at 1
    do_events(1'b0, 1'b1, 1'b0);
    do_tick();
    expect_out(3'd3, 1'b0, 1'b1, 4'd3, 4'd1, 4'd0, 2'b00);
    check_out("point_cnt_one");
    #2 RESET_N = 1'b0;
    #1;
    expect_out(3'd0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("async_reset");
    step(1);
    RESET_N = 1'b1;
    step(1);
    do_tick();
    expect_out(3'd0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 2'b00);
    check_out("tick_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
